// File: rtl/spram_pingpong_ctrl.sv
// spram_pingpong_ctrl: sequences a two-bank single-port RAM ping-pong buffer
// between a capture stream (writer, no backpressure) and a valid/ready drain
// stream (reader). The writer fills one bank while the reader drains the other.
// When the reader cannot take a full bank, incoming samples are dropped and
// flagged on the sticky oOvf output.
//
// Optional build macro SPRAM_PP_OVF_CNT_EN adds oOvf_Cnt, a saturating 16-bit
// count of dropped samples.
//
// Handshake: a word moves on the output stream in any cycle where oRd_Valid
// and iRd_Ready are both high. Once oRd_Valid is raised, oRd_Valid, oRd_Data
// and oRd_Last hold until that transfer happens.
//
// FSM state is kept in w_state / r_state so checkers can observe it directly.
module spram_pingpong_ctrl #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14,
  parameter int DW    = 16
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iCap_SOF,
  input  logic          iCap_Valid,
  input  logic [DW-1:0] iCap_Data,
  output logic          oWr_Which,
  output logic [AW-1:0] oWr_Addr,
  output logic [DW-1:0] oWr_Data,
  output logic          oWr_En,
  output logic [AW-1:0] oRd_Addr,
  input  logic [DW-1:0] iRd_Data,
  output logic          oBlk_Rdy,
  output logic          oRd_Valid,
  output logic [DW-1:0] oRd_Data,
  output logic          oRd_Last,
  input  logic          iRd_Ready,
  output logic          oOvf
`ifdef SPRAM_PP_OVF_CNT_EN
  ,
  output logic [15:0]   oOvf_Cnt
`endif
);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_FILL  = 2'd1;
  localparam logic [1:0] W_WAIT  = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_DRAIN = 2'd1;
  localparam logic [1:0] R_FLUSH = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]    w_state;
  logic [1:0]    r_state;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;

  // write-side decode
  logic          wr_take;
  logic          wr_zero;
  logic          wr_full;
  logic          swap;
  logic          drop;
  logic [AW-1:0] wr_addr;

  // read-side decode
  logic          rd_idle;
  logic          rd_pop;
  logic          rd_issue;
  logic          rd_issue_last;
  logic [1:0]    occ_after;
  logic [1:0]    rd_load;

  // read pipeline and 2-entry output FIFO
  logic          rd_pend;
  logic          rd_pend_last;
  logic [DW-1:0] f_data [0:1];
  logic          f_last [0:1];
  logic          f_wr_ptr;
  logic          f_rd_ptr;
  logic [1:0]    f_cnt;

  // The reader is free to accept a bank only when it is idle and has not
  // already been handed one that it has yet to pick up.
  assign rd_idle = (r_state == R_IDLE) && !oBlk_Rdy;

  // Decide per cycle whether the incoming sample is written, dropped or ignored.
  // W_WAIT also covers the single cycle right after a bank fills, so a free
  // reader lets that cycle's sample go straight to address 0 of the new bank.
  always_comb begin
    wr_take = 1'b0;
    wr_zero = 1'b0;
    swap    = 1'b0;
    drop    = 1'b0;
    case (w_state)
      W_IDLE: begin
        wr_take = iCap_Valid & iCap_SOF;
        wr_zero = 1'b1;
      end
      W_FILL: begin
        wr_take = iCap_Valid;
        wr_zero = iCap_SOF;
      end
      W_WAIT: begin
        if (rd_idle) begin
          swap    = 1'b1;
          wr_take = iCap_Valid;
          wr_zero = 1'b1;
        end else begin
          drop    = iCap_Valid;
        end
      end
      default: ;
    endcase
  end

  assign wr_addr = wr_zero ? '0 : wr_cnt;
  assign wr_full = wr_take && (wr_addr == LAST_ADDR);

  // Registered write port, bank select, write counter, writer FSM and overflow.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      w_state   <= W_IDLE;
      wr_cnt    <= '0;
      oWr_Which <= 1'b0;
      oWr_Addr  <= '0;
      oWr_Data  <= '0;
      oWr_En    <= 1'b0;
      oOvf      <= 1'b0;
    end else begin
      oWr_En <= wr_take;
      if (wr_take) begin
        oWr_Addr <= wr_addr;
        oWr_Data <= iCap_Data;
        wr_cnt   <= wr_full ? '0 : wr_addr + AW'(1);
      end
      if (swap) oWr_Which <= ~oWr_Which;
      if (drop) oOvf <= 1'b1;
      if (wr_take)
        w_state <= wr_full ? W_WAIT : W_FILL;
      else if (swap)
        w_state <= W_FILL;
      else if (w_state > W_WAIT)
        w_state <= W_IDLE;
    end
  end

`ifdef SPRAM_PP_OVF_CNT_EN
  // Saturating count of dropped samples.
  always_ff @(posedge iClk) begin
    if (iRst)
      oOvf_Cnt <= '0;
    else if (drop && (oOvf_Cnt != 16'hFFFF))
      oOvf_Cnt <= oOvf_Cnt + 16'd1;
  end
`endif

  // A read may be issued only while the word in flight plus the FIFO words
  // left after this cycle's transfer stay below two, so the FIFO never
  // overflows yet sustains one word per cycle with iRd_Ready held high.
  // rd_cnt rests at zero while idle, so address 0 is already on oRd_Addr
  // in the cycle oBlk_Rdy is high and the first read goes out then.
  assign rd_pop        = oRd_Valid & iRd_Ready;
  assign occ_after     = f_cnt - {1'b0, rd_pop};
  assign rd_load       = occ_after + {1'b0, rd_pend};
  assign rd_issue      = (((r_state == R_IDLE) && oBlk_Rdy) || (r_state == R_DRAIN))
                         && (rd_load < 2'd2);
  assign rd_issue_last = rd_issue && (rd_cnt == LAST_ADDR);
  assign oRd_Addr      = rd_cnt;

  // Reader FSM, read counter, block-ready flag and the one-deep read pipeline.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state      <= R_IDLE;
      rd_cnt       <= '0;
      oBlk_Rdy     <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue_last;
      if (rd_issue) rd_cnt <= rd_issue_last ? '0 : rd_cnt + AW'(1);
      if (swap)
        oBlk_Rdy <= 1'b1;
      else if (r_state == R_IDLE)
        oBlk_Rdy <= 1'b0;
      if (rd_issue_last)
        r_state <= R_FLUSH;
      else begin
        case (r_state)
          R_IDLE:  if (oBlk_Rdy) r_state <= R_DRAIN;
          R_DRAIN: ;
          R_FLUSH: if (rd_pop && oRd_Last) r_state <= R_IDLE;
          default: r_state <= R_IDLE;
        endcase
      end
    end
  end

  // Output FIFO: captures RAM read data one cycle after the address was issued.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      f_data[0] <= '0;
      f_data[1] <= '0;
      f_last[0] <= 1'b0;
      f_last[1] <= 1'b0;
      f_wr_ptr  <= 1'b0;
      f_rd_ptr  <= 1'b0;
      f_cnt     <= '0;
    end else begin
      if (rd_pend) begin
        f_data[f_wr_ptr] <= iRd_Data;
        f_last[f_wr_ptr] <= rd_pend_last;
        f_wr_ptr         <= ~f_wr_ptr;
      end
      if (rd_pop) f_rd_ptr <= ~f_rd_ptr;
      f_cnt <= f_cnt + {1'b0, rd_pend} - {1'b0, rd_pop};
    end
  end

  assign oRd_Valid = (f_cnt != 2'd0);
  assign oRd_Data  = f_data[f_rd_ptr];
  assign oRd_Last  = f_last[f_rd_ptr];

endmodule

// File: tb/tb_spram_pingpong_ctrl.sv
// Bench for spram_pingpong_ctrl (DEPTH=16). A behavioural model tracks the
// bank being filled as a sample list and hands a full bank to the reader when
// the reader is free; expected writes and output words go into queues that a
// separate negedge monitor pops and compares. Build with SPRAM_PP_OVF_CNT_EN
// to also check oOvf_Cnt.
module tb_spram_pingpong_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 16;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iCap_SOF;
  logic          iCap_Valid;
  logic [DW-1:0] iCap_Data;
  logic          oWr_Which;
  logic [AW-1:0] oWr_Addr;
  logic [DW-1:0] oWr_Data;
  logic          oWr_En;
  logic [AW-1:0] oRd_Addr;
  logic [DW-1:0] iRd_Data;
  logic          oBlk_Rdy;
  logic          oRd_Valid;
  logic [DW-1:0] oRd_Data;
  logic          oRd_Last;
  logic          iRd_Ready;
  logic          oOvf;
`ifdef SPRAM_PP_OVF_CNT_EN
  logic [15:0]   oOvf_Cnt;
`endif

  spram_pingpong_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iCap_SOF  (iCap_SOF),
    .iCap_Valid(iCap_Valid),
    .iCap_Data (iCap_Data),
    .oWr_Which (oWr_Which),
    .oWr_Addr  (oWr_Addr),
    .oWr_Data  (oWr_Data),
    .oWr_En    (oWr_En),
    .oRd_Addr  (oRd_Addr),
    .iRd_Data  (iRd_Data),
    .oBlk_Rdy  (oBlk_Rdy),
    .oRd_Valid (oRd_Valid),
    .oRd_Data  (oRd_Data),
    .oRd_Last  (oRd_Last),
    .iRd_Ready (iRd_Ready),
    .oOvf      (oOvf)
`ifdef SPRAM_PP_OVF_CNT_EN
    ,
    .oOvf_Cnt  (oOvf_Cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 iClk = ~iClk;

  // ---------------- two-bank RAM with synchronous read ----------------
  logic [DW-1:0] mem [0:2*DEPTH-1];
  always @(posedge iClk) begin
    if (oWr_En) mem[{oWr_Which, oWr_Addr}] <= oWr_Data;
    iRd_Data <= mem[{~oWr_Which, oRd_Addr}];
  end

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, want);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW:0]      exp_q[$];        // {last, data} of output words
  logic [AW+DW:0]   exp_wr_q[$];     // {bank, addr, data} of RAM writes
  int               exp_wr_cyc_q[$]; // cycle in which each write's sample arrived
  logic [DW-1:0]    m_buf[$];        // samples of the bank being filled
  logic             m_bank = 1'b0;
  logic             m_in_frame = 1'b0;
  logic             m_full = 1'b0;
  logic             m_busy = 1'b0;
  logic             m_hand_last = 1'b0;
  int               m_drops = 0;
  int               n_last_acc = 0;  // stepped by the monitor only
  int               seen_last = 0;
  // expectations for the current cycle's outputs
  logic             e_which = 1'b0;
  logic             e_blk = 1'b0;
  logic             e_ovf = 1'b0;
  logic [15:0]      e_cnt = 16'd0;

  task automatic push_wr(input int addr, input logic [DW-1:0] d);
    exp_wr_q.push_back({m_bank, AW'(addr), d});
    exp_wr_cyc_q.push_back(cyc);
  endtask

  task automatic model_step(input logic rst, input logic v, input logic sof,
                            input logic [DW-1:0] d);
    e_which = m_bank;
    e_blk   = m_hand_last;
    e_ovf   = (m_drops != 0);
    e_cnt   = (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
    m_hand_last = 1'b0;
    if (n_last_acc != seen_last) begin
      m_busy    = 1'b0;
      seen_last = n_last_acc;
    end
    if (rst) begin
      m_bank = 1'b0; m_in_frame = 1'b0; m_full = 1'b0; m_busy = 1'b0; m_drops = 0;
      m_buf.delete(); exp_q.delete(); exp_wr_q.delete(); exp_wr_cyc_q.delete();
      return;
    end
    if (m_full && !m_busy) begin
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), m_buf[i]});
      m_buf.delete();
      m_busy = 1'b1;
      m_full = 1'b0;
      m_bank = ~m_bank;
      m_hand_last = 1'b1;
    end
    if (v) begin
      if (m_full) m_drops++;
      else if (sof) begin
        m_in_frame = 1'b1;
        m_buf.delete();
        push_wr(0, d);
        m_buf.push_back(d);
      end else if (m_in_frame) begin
        push_wr(m_buf.size(), d);
        m_buf.push_back(d);
      end
      if (m_buf.size() == DEPTH) m_full = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic v, input logic sof,
                       input logic [DW-1:0] d, input logic rdy);
    iRst = rst; iCap_Valid = v; iCap_SOF = sof; iCap_Data = d; iRd_Ready = rdy;
    cyc++;
    model_step(rst, v, sof, d);
    @(posedge iClk);
    #1;
  endtask

  // rdy_mode: 0 low, 1 high, 2 toggle each cycle, 3 random
  function automatic logic pick_rdy(input int rdy_mode);
    case (rdy_mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return cyc[0];
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic send_frame(input int n, input int rdy_mode);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b1, (i == 0), DW'($urandom), pick_rdy(rdy_mode));
  endtask

  task automatic idle(input int n, input int rdy_mode);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, pick_rdy(rdy_mode));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_wr_en"},   oWr_En,    1'b0);
    check({tag, "_which"},   oWr_Which, 1'b0);
    check({tag, "_wr_addr"}, oWr_Addr,  '0);
    check({tag, "_rd_addr"}, oRd_Addr,  '0);
    check({tag, "_blk_rdy"}, oBlk_Rdy,  1'b0);
    check({tag, "_valid"},   oRd_Valid, 1'b0);
    check({tag, "_last"},    oRd_Last,  1'b0);
    check({tag, "_ovf"},     oOvf,      1'b0);
`ifdef SPRAM_PP_OVF_CNT_EN
    check({tag, "_ovf_cnt"}, oOvf_Cnt,  16'd0);
`endif
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic stalled_prev = 1'b0;
  logic lat_pend = 1'b0;
  int   blk_cyc = 0;

  always @(negedge iClk) begin
    if (iRst || !run) begin
      stalled_prev = 1'b0;
      lat_pend     = 1'b0;
    end else begin
      logic exp_en;
      check("wr_which", oWr_Which, e_which);
      check("blk_rdy", oBlk_Rdy, e_blk);
      check("ovf", oOvf, e_ovf);
`ifdef SPRAM_PP_OVF_CNT_EN
      check("ovf_cnt", oOvf_Cnt, e_cnt);
`endif
      exp_en = (exp_wr_q.size() > 0) && (exp_wr_cyc_q[0] == cyc - 1);
      check("wr_en", oWr_En, exp_en);
      if (exp_en) begin
        if (oWr_En) check("wr_word", {oWr_Which, oWr_Addr, oWr_Data}, exp_wr_q[0]);
        void'(exp_wr_q.pop_front());
        void'(exp_wr_cyc_q.pop_front());
      end
      if (e_blk) begin
        lat_pend = 1'b1;
        blk_cyc  = cyc;
      end
      if (stalled_prev) check("rd_hold_valid", oRd_Valid, 1'b1);
      if (oRd_Valid) begin
        if (lat_pend) begin
          check("first_latency", cyc - blk_cyc, 2);
          lat_pend = 1'b0;
        end
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL rd_unexpected at cycle %0d: got word %0h, none expected", cyc, oRd_Data);
        end else begin
          check("rd_word", {oRd_Last, oRd_Data}, exp_q[0]);
          if (iRd_Ready) begin
            if (exp_q[0][DW]) n_last_acc++;
            void'(exp_q.pop_front());
          end
        end
      end
      stalled_prev = oRd_Valid && !iRd_Ready;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    iRst = 1'b1; iCap_Valid = 1'b0; iCap_SOF = 1'b0; iCap_Data = '0; iRd_Ready = 1'b0;
    @(posedge iClk);
    #1;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    run = 1'b1;
    reset_checks("reset");

    // one frame of 0..15, reader always ready
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, (i == 0), DW'(i), 1'b1);
    idle(30, 1);

    // 48 continuous samples: banks alternate, nothing dropped
    send_frame(48, 1);
    idle(30, 1);

    // reader stalled after bank 0 is handed over: 4 of 36 samples dropped
    send_frame(36, 0);
    idle(5, 0);
    check("stall_ovf", oOvf, 1'b1);
`ifdef SPRAM_PP_OVF_CNT_EN
    check("stall_ovf_cnt", oOvf_Cnt, 16'd4);
`endif
    idle(60, 1);

    // SOF at sample 7 restarts the bank without a swap
    send_frame(7, 1);
    send_frame(DEPTH, 1);
    idle(30, 1);

    // reader ready toggling during the drain
    send_frame(DEPTH, 2);
    idle(50, 2);

    // reset while draining
    send_frame(DEPTH, 1);
    idle(4, 1);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    reset_checks("mid_drain");

    // random traffic with occasional SOF and random backpressure
    for (int i = 0; i < 600; i++)
      drive(1'b0, ($urandom_range(0, 9) < 8), ($urandom_range(0, 59) == 0),
            DW'($urandom), pick_rdy((i / 150) % 2 == 0 ? 3 : 1));

    // let everything outstanding come out
    begin
      int k;
      k = 0;
      while ((exp_q.size() > 0 || m_full || exp_wr_q.size() > 0) && k < 300) begin
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        k++;
      end
      n_vec++;
      if (exp_q.size() > 0 || m_full || exp_wr_q.size() > 0) begin
        n_bad++;
        $display("FAIL drain_timeout: %0d words and %0d writes still pending, required 0",
                 exp_q.size(), exp_wr_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spram_pingpong_ctrl.md
Name: spram_pingpong_ctrl

Overview:
Sequences the two-bank single-port RAM ping-pong buffer between the IR capture stream (writer) and the DDR writer (reader).
- Generates write addresses/enables and the bank-select line for the writer.
- Swaps banks when a bank fills and the reader is idle.
- Drains the filled bank to the DDR side over a valid/ready stream.
- Drops and counts capture samples when the reader falls behind.

Parameters:
DEPTH, 16384, words per bank; a bank is full after DEPTH writes (sims override to 16)
AW, 14, address width, ceil(log2(DEPTH))
DW, 16, data width

Ports:
iClk  in  1  clock
iRst  in  1  synchronous active-high reset
iCap_SOF  in  1  start of frame, qualified by iCap_Valid
iCap_Valid  in  1  capture sample valid; no backpressure
iCap_Data  in  DW  capture sample
oWr_Which  out  1  bank being written (0/1); the other bank is read
oWr_Addr  out  AW  write address
oWr_Data  out  DW  write data
oWr_En  out  1  write strobe
oRd_Addr  out  AW  read address to the non-written bank
iRd_Data  in  DW  RAM read data, valid 1 cycle after oRd_Addr
oBlk_Rdy  out  1  a full bank is waiting to be drained
oRd_Valid  out  1  output stream valid
oRd_Data  out  DW  output stream data
oRd_Last  out  1  marks word DEPTH-1 of a bank
iRd_Ready  in  1  downstream accept
oOvf  out  1  sticky: a sample was dropped; cleared only by reset

Behaviour:
Reset: all outputs 0, oWr_Which=0, both FSMs idle, write counter 0, output FIFO empty.

Write FSM W_IDLE -> W_FILL -> W_WAIT:
- W_IDLE: ignore samples until iCap_Valid&iCap_SOF, then write that sample at addr 0 and enter W_FILL.
- Write path is registered. A sample accepted in cycle t appears as oWr_En=1 with oWr_Addr/oWr_Data at edge t+1; oWr_En=0 otherwise.
- W_FILL: each valid sample is written at the counter value, then the counter increments.
- Bank full, reader idle: when the write to DEPTH-1 is issued at edge t+1 and the reader is idle, the following happen at edge t+2:
  - oWr_Which toggles.
  - The counter is already 0.
  - oBlk_Rdy rises.
  - A sample arriving in cycle t+1 is written at addr 0 of the new bank with no gap.
- Bank full, reader busy: enter W_WAIT. Samples are dropped and oOvf is set. When the reader goes idle, the swap happens (as above) the next cycle and the FSM returns to W_FILL at addr 0.
- iCap_SOF in W_FILL: the partial bank is discarded with no swap; the SOF sample is written at addr 0.
- iCap_SOF in W_WAIT: dropped like any other sample.

Read FSM R_IDLE -> R_DRAIN -> R_FLUSH:
- R_IDLE -> R_DRAIN: on oBlk_Rdy. oBlk_Rdy drops the same edge; the read counter is cleared.
- R_DRAIN: oRd_Addr is issued only when outstanding reads plus FIFO occupancy < 2. Each iRd_Data is captured 1 cycle later into a 2-entry output FIFO.
- Output FIFO drives oRd_Valid/oRd_Data/oRd_Last. A word transfers on oRd_Valid&iRd_Ready. oRd_Data/oRd_Last hold stable while oRd_Valid&!iRd_Ready.
- After addr DEPTH-1 is issued, go to R_FLUSH.
- R_FLUSH -> R_IDLE: when the word with oRd_Last is accepted. Reader is "idle" only in R_IDLE.
- Throughput: 1 word/cycle with iRd_Ready held high. First oRd_Valid appears 2 cycles after oBlk_Rdy.

Simultaneous events:
- Reader returning to R_IDLE in the same cycle the writer fills: swap proceeds without entering W_WAIT.
- iRst mid-operation: everything is abandoned and the reset values above apply next edge.

Optional Feature:
SPRAM_PP_OVF_CNT_EN
- Defined: adds port oOvf_Cnt out 16. It counts dropped samples, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: the port is absent and only the sticky oOvf flag is provided.

Test Plan:
- DEPTH=16, SOF+16 continuous samples 0x0000..0x000F, iRd_Ready=1 -> writes addr 0..15 on bank 0; oWr_Which=1 on next edge; 16 words 0x0000..0x000F out; oRd_Last on 0x000F.
- Continuous 48 samples, iRd_Ready=1 -> banks alternate 0,1,0; no drop, oOvf=0; every output word matches input order.
- iRd_Ready=0 after bank 0 ready; 20 further samples -> bank 1 fills after 16; 4 samples dropped; oOvf=1; oOvf_Cnt=4 when enabled; oRd_Data stable while stalled.
- SOF at sample 7 of a bank -> no swap, no oBlk_Rdy; the SOF sample is written at addr 0.
- iRd_Ready toggled 1,0,1,0 during drain -> 16 words delivered exactly once, in order, none duplicated.
- iRst during R_DRAIN -> next edge: oRd_Valid=0, oBlk_Rdy=0, oWr_Which=0, oOvf=0.
